// File: rtl/prbs_frame_tx_if.sv
// AXI-Stream style beat channel with SOF marker, shared by the PRBS source and its sink.
interface prbs_frame_tx_if #(
  parameter int unsigned C_DATA_WIDTH = 32
);
  logic                    tready;
  logic                    tvalid;
  logic [C_DATA_WIDTH-1:0] tdata;
  logic                    sof;
  logic                    tlast;

  modport master (
    input  tready,
    output tvalid,
    output tdata,
    output sof,
    output tlast
  );

  modport slave (
    output tready,
    input  tvalid,
    input  tdata,
    input  sof,
    input  tlast
  );
endinterface

// File: rtl/prbs_frame_tx.sv
// Framed PRBS31 source: fixed-length frames separated by idle gaps, with SOF/TLAST and
// full backpressure. The sequence runs on across frames and reloads only on start.
module prbs_frame_tx #(
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_LEN_WIDTH  = 16,
  parameter int unsigned C_CNT_WIDTH  = 16
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic [30:0]            i_seed,
  input  logic [C_LEN_WIDTH-1:0] i_frame_len,
  input  logic [C_LEN_WIDTH-1:0] i_gap_len,
  input  logic [C_CNT_WIDTH-1:0] i_num_frames,
  prbs_frame_tx_if.master        m_axis,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [C_CNT_WIDTH-1:0] o_frames_sent
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

  // One beat worth of LFSR steps; the first generated bit lands in the MSB.
  function automatic logic [30+C_DATA_WIDTH:0] prbs_step(input logic [30:0] s_in);
    logic [30:0]             s;
    logic [C_DATA_WIDTH-1:0] d;
    logic                    n;
    s = s_in;
    d = '0;
    for (int i = 0; i < C_DATA_WIDTH; i++) begin
      n = s[30] ^ s[27];
      s = {s[29:0], n};
      d = {d[C_DATA_WIDTH-2:0], n};
    end
    return {s, d};
  endfunction

  state_e                  state_q;
  logic [30:0]             lfsr_q;
  logic [C_LEN_WIDTH-1:0]  len_q, gap_q, beat_cnt_q, gap_cnt_q;
  logic [C_CNT_WIDTH-1:0]  num_q, frames_q;
  logic                    stop_q;
  logic                    tvalid_q, sof_q, tlast_q, done_q;
  logic [C_DATA_WIDTH-1:0] tdata_q;

  logic [30:0]             lfsr_nxt;
  logic [C_DATA_WIDTH-1:0] beat_nxt;
  logic [C_LEN_WIDTH-1:0]  beat_idx_nxt, last_idx;
  logic [C_CNT_WIDTH-1:0]  frames_nxt;
  logic                    run_end, gap_last;

  always_comb begin
    {lfsr_nxt, beat_nxt} = prbs_step(lfsr_q);
    beat_idx_nxt         = beat_cnt_q + 1'b1;
    last_idx             = len_q - 1'b1;
    frames_nxt           = frames_q + 1'b1;
    // A stop arriving on the tlast handshake itself still ends the run after this frame.
    run_end              = ((num_q != '0) && (frames_nxt == num_q)) || stop_q || i_stop;
    gap_last             = (gap_cnt_q == gap_q - 1'b1);
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state_q    <= StIdle;
      lfsr_q     <= 31'd1;
      len_q      <= '0;
      gap_q      <= '0;
      num_q      <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      frames_q   <= '0;
      stop_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      sof_q      <= 1'b0;
      tlast_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            len_q    <= (i_frame_len == '0) ? C_LEN_WIDTH'(1) : i_frame_len;
            gap_q    <= i_gap_len;
            num_q    <= i_num_frames;
            lfsr_q   <= (i_seed == '0) ? 31'd1 : i_seed;
            frames_q <= '0;
            stop_q   <= 1'b0;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          if (i_stop) stop_q <= 1'b1;
          lfsr_q     <= lfsr_nxt;
          tdata_q    <= beat_nxt;
          tvalid_q   <= 1'b1;
          sof_q      <= 1'b1;
          tlast_q    <= (last_idx == '0);
          beat_cnt_q <= '0;
          state_q    <= StSend;
        end
        StSend: begin
          if (i_stop) stop_q <= 1'b1;
          if (tvalid_q && m_axis.tready) begin
            if (!tlast_q) begin
              lfsr_q     <= lfsr_nxt;
              tdata_q    <= beat_nxt;
              sof_q      <= 1'b0;
              tlast_q    <= (beat_idx_nxt == last_idx);
              beat_cnt_q <= beat_idx_nxt;
            end else begin
              frames_q <= frames_nxt;
              if (run_end) begin
                tvalid_q <= 1'b0;
                tdata_q  <= '0;
                sof_q    <= 1'b0;
                tlast_q  <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= StIdle;
              end else if (gap_q != '0) begin
                tvalid_q  <= 1'b0;
                sof_q     <= 1'b0;
                tlast_q   <= 1'b0;
                gap_cnt_q <= '0;
                state_q   <= StGap;
              end else begin
                lfsr_q     <= lfsr_nxt;
                tdata_q    <= beat_nxt;
                sof_q      <= 1'b1;
                tlast_q    <= (last_idx == '0);
                beat_cnt_q <= '0;
              end
            end
          end
        end
        StGap: begin
          if (i_stop) begin
            tdata_q <= '0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (gap_last) begin
            lfsr_q     <= lfsr_nxt;
            tdata_q    <= beat_nxt;
            tvalid_q   <= 1'b1;
            sof_q      <= 1'b1;
            tlast_q    <= (last_idx == '0);
            beat_cnt_q <= '0;
            state_q    <= StSend;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.sof    = sof_q;
  assign m_axis.tlast  = tlast_q;
  assign o_busy        = (state_q != StIdle);
  assign o_done        = done_q;
  assign o_frames_sent = frames_q;

endmodule

// File: tb/tb_prbs_frame_tx.sv
// Scoreboard bench for prbs_frame_tx: expected beats are queued per run and popped on handshake;
// a second 64-bit instance is checked against a free-running PRBS model.
module tb_prbs_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [30:0] seed = '0;
  logic [15:0] frame_len = '0;
  logic [15:0] gap_len = '0;
  logic [15:0] num_frames = '0;
  logic        rand_ready = 1'b0;

  logic        busy32, done32, busy64, done64;
  logic [15:0] frames32, frames64;

  prbs_frame_tx_if #(.C_DATA_WIDTH(32)) axis32 ();
  prbs_frame_tx_if #(.C_DATA_WIDTH(64)) axis64 ();

  prbs_frame_tx #(.C_DATA_WIDTH(32), .C_LEN_WIDTH(16), .C_CNT_WIDTH(16)) u_dut32 (
    .i_aclk        (clk),
    .i_areset      (rst),
    .i_start       (start),
    .i_stop        (stop),
    .i_seed        (seed),
    .i_frame_len   (frame_len),
    .i_gap_len     (gap_len),
    .i_num_frames  (num_frames),
    .m_axis        (axis32),
    .o_busy        (busy32),
    .o_done        (done32),
    .o_frames_sent (frames32)
  );

  prbs_frame_tx #(.C_DATA_WIDTH(64), .C_LEN_WIDTH(16), .C_CNT_WIDTH(16)) u_dut64 (
    .i_aclk        (clk),
    .i_areset      (rst),
    .i_start       (start),
    .i_stop        (stop),
    .i_seed        (seed),
    .i_frame_len   (frame_len),
    .i_gap_len     (gap_len),
    .i_num_frames  (num_frames),
    .m_axis        (axis64),
    .o_busy        (busy64),
    .o_done        (done64),
    .o_frames_sent (frames64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        last;
    int          bubbles;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    hs_cnt = 0;
  int    done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference PRBS31: n = s[30]^s[27], shifted in; first bit ends up in the MSB.
  task automatic prbs_model(input int w, input logic [30:0] s_in, output logic [30:0] s_out,
                            output logic [63:0] d);
    logic [30:0] s;
    logic        n;
    s = s_in;
    d = '0;
    for (int k = 0; k < w; k++) begin
      n = s[30] ^ s[27];
      s = {s[29:0], n};
      d = {d[62:0], n};
    end
    s_out = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    axis64.tready = 1'b1;
    axis32.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis32.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop, stall stability, bubble count, done pulses, 64-bit stream.
  logic        stall = 1'b0;
  logic [31:0] sv_data;
  logic        sv_sof, sv_last;
  int          bubbles = 0;
  logic [30:0] m64 = 31'd1;

  always @(negedge clk) begin
    beat_t       e;
    logic [63:0] d64;
    if (rst) begin
      stall   = 1'b0;
      bubbles = 0;
      m64     = 31'd1;
    end else begin
      if (stall) begin
        check("hold_valid", 64'(axis32.tvalid), 64'd1);
        check("hold_data", 64'(axis32.tdata), 64'(sv_data));
        check("hold_sof", 64'(axis32.sof), 64'(sv_sof));
        check("hold_last", 64'(axis32.tlast), 64'(sv_last));
      end
      if (done32) done_cnt++;
      if (axis32.tvalid && axis32.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(axis32.tdata), 64'(e.data));
          check("beat_sof", 64'(axis32.sof), 64'(e.sof));
          check("beat_last", 64'(axis32.tlast), 64'(e.last));
          check("beat_bubbles", 64'(bubbles), 64'(e.bubbles));
        end
        hs_cnt++;
        bubbles = 0;
      end else if (busy32 && !axis32.tvalid) begin
        bubbles++;
      end
      stall   = axis32.tvalid && !axis32.tready;
      sv_data = axis32.tdata;
      sv_sof  = axis32.sof;
      sv_last = axis32.tlast;
      if (axis64.tvalid && axis64.tready) begin
        prbs_model(64, m64, m64, d64);
        check("w64_data", axis64.tdata, d64);
      end
      // Start is held across this negedge, so it lands at the next posedge.
      if (start && !busy64) m64 = (seed == '0) ? 31'd1 : seed;
    end
  end

  task automatic push_run(input logic [30:0] sd, input int len, input int gap, input int nfr);
    logic [30:0] s;
    logic [63:0] d;
    beat_t       e;
    int          el;
    el = (len == 0) ? 1 : len;
    s  = (sd == '0) ? 31'd1 : sd;
    for (int f = 0; f < nfr; f++) begin
      for (int b = 0; b < el; b++) begin
        prbs_model(32, s, s, d);
        e.data    = d[31:0];
        e.sof     = (b == 0);
        e.last    = (b == el - 1);
        e.bubbles = (f == 0 && b == 0) ? 1 : ((b == 0) ? gap : 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_run(input logic [30:0] sd, input int len, input int gap, input int num,
                        input int exp_frames, input int stop_hs, input bit poke,
                        input logic [31:0] first_exp);
    int hs0, d0;
    bit stop_sent;
    push_run(sd, len, gap, exp_frames);
    hs0        = hs_cnt;
    d0         = done_cnt;
    seed       = sd;
    frame_len  = 16'(len);
    gap_len    = 16'(gap);
    num_frames = 16'(num);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    // Config is latched; these must not disturb the run.
    seed       = 31'h5a5a_1234;
    frame_len  = 16'd7;
    gap_len    = 16'd5;
    num_frames = 16'd9;
    stop_sent  = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      if (first_exp != '0 && c == 0) check("load_valid", 64'(axis32.tvalid), 64'd0);
      if (first_exp != '0 && c == 1) begin
        check("latency_valid", 64'(axis32.tvalid), 64'd1);
        check("first_tdata", 64'(axis32.tdata), 64'(first_exp));
      end
      if (stop_hs >= 0 && !stop_sent && hs_cnt - hs0 >= stop_hs) begin
        stop      = 1'b1;
        stop_sent = 1'b1;
      end
      if (poke && c == 5) start = 1'b1;
      tick();
      stop  = 1'b0;
      start = 1'b0;
    end
    check("run_done", 64'(done_cnt != d0), 64'd1);
    tick();
    tick();
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("frames_sent", 64'(frames32), 64'(exp_frames));
    check("busy_idle", 64'(busy32), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, 64'(axis32.tvalid), 64'd0);
    check({tag, "_tdata"}, 64'(axis32.tdata), 64'd0);
    check({tag, "_sof"}, 64'(axis32.sof), 64'd0);
    check({tag, "_tlast"}, 64'(axis32.tlast), 64'd0);
    check({tag, "_busy"}, 64'(busy32), 64'd0);
    check({tag, "_done"}, 64'(done32), 64'd0);
    check({tag, "_frames"}, 64'(frames32), 64'd0);
    check({tag, "_w64_tvalid"}, 64'(axis64.tvalid), 64'd0);
  endtask

  initial begin
    int hs0;
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1-beat-per-cycle single frame with known first word.
    do_run(31'd1, 4, 0, 1, 1, -1, 1'b0, 32'h0000_0012);

    // Same stream under random backpressure.
    rand_ready = 1'b1;
    do_run(31'd1, 4, 0, 1, 1, -1, 1'b0, 32'h0000_0012);
    rand_ready = 1'b0;
    repeat (2) tick();

    // Gapped frames, with a start pulse while busy that must be ignored.
    do_run(31'd1, 3, 2, 3, 3, -1, 1'b1, '0);

    // Zero length is one beat, back-to-back.
    do_run(31'd7, 0, 0, 2, 2, -1, 1'b0, '0);

    // Endless run stopped mid frame 2 (handshake 13 = frame 2 beat 5).
    do_run(31'd9, 8, 0, 0, 2, 13, 1'b0, '0);

    // Reset mid-frame.
    push_run(31'd1, 8, 0, 1);
    hs0        = hs_cnt;
    seed       = 31'd1;
    frame_len  = 16'd8;
    gap_len    = 16'd0;
    num_frames = 16'd1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    for (int c = 0; c < 100 && hs_cnt - hs0 < 3; c++) tick();
    check("pre_reset_beats", 64'(hs_cnt - hs0 >= 3), 64'd1);
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    exp_q.delete();
    tick();

    // Seed 0 behaves as seed 1.
    do_run(31'd0, 5, 1, 2, 2, -1, 1'b0, 32'h0000_0012);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
